reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 156 +++++++++++++++
 tb/tb_reg_dump_reader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Debug register-range dump engine: reads regfile entries first..last and streams them out over a valid/ready port.
// Optional running XOR checksum on csum_o is compiled in when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
    parameter int SKIP_X0 = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [4:0]  first_addr_i,
    input  logic [4:0]  last_addr_i,
    output logic        rd_reg_en_o,
    output logic [4:0]  rd_reg_addr_o,
    input  logic [31:0] rd_reg_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [4:0]  dump_addr_o,
    output logic [31:0] dump_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] csum_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cur_reg, cur_next;
    logic [4:0]  last_reg, last_next;
    logic [4:0]  addr_out_reg, addr_out_next;
    logic [31:0] data_out_reg, data_out_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;

    logic skip_cur;
    logic handshake;
    logic accept;

    // x0 is hardwired zero, so its read can be skipped entirely.
    assign skip_cur  = (SKIP_X0 != 0) && (cur_reg == 5'd0);
    assign handshake = (state_reg == S_OUT) && dump_ready_i;
    assign accept    = (state_reg == S_IDLE) && start_i && !abort_i &&
                       (first_addr_i <= last_addr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            cur_reg      <= 5'd0;
            last_reg     <= 5'd0;
            addr_out_reg <= 5'd0;
            data_out_reg <= 32'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            last_reg     <= last_next;
            addr_out_reg <= addr_out_next;
            data_out_reg <= data_out_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        last_next     = last_reg;
        addr_out_next = addr_out_reg;
        data_out_next = data_out_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if (first_addr_i <= last_addr_i) begin
                        cur_next   = first_addr_i;
                        last_next  = last_addr_i;
                        state_next = S_ISSUE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Data is valid here for both combinational and one-cycle registered regfile reads.
                data_out_next = skip_cur ? 32'd0 : rd_reg_data_i;
                addr_out_next = cur_reg;
                state_next    = S_OUT;
            end
            S_OUT: begin
                if (dump_ready_i) begin
                    if (cur_reg == last_reg) begin
                        state_next = S_DONE;
                    end else begin
                        cur_next   = cur_reg + 5'd1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort_i && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            done_next  = 1'b0;
        end
    end

    assign rd_reg_en_o   = (state_reg == S_ISSUE) && !skip_cur;
    assign rd_reg_addr_o = cur_reg;
    assign dump_valid_o  = (state_reg == S_OUT);
    assign dump_addr_o   = addr_out_reg;
    assign dump_data_o   = data_out_reg;
    assign busy_o        = (state_reg != S_IDLE);
    assign done_o        = done_reg;
    assign err_o         = err_reg;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] csum_reg;

    // A word handshaken in an abort cycle still counts as delivered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_reg <= 32'd0;
        end else if (accept) begin
            csum_reg <= 32'd0;
        end else if (handshake) begin
            csum_reg <= csum_reg ^ data_out_reg;
        end
    end

    assign csum_o = csum_reg;
`else
    logic unused_ok;
    assign unused_ok = accept ^ handshake;
    assign csum_o    = 32'd0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: transaction-level model plus directed scenarios with literal expectations.
module tb_reg_dump_reader;

    localparam int SKIP = 1;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [4:0]  first_addr_i = 5'd0;
    logic [4:0]  last_addr_i = 5'd0;
    logic        rd_reg_en_o;
    logic [4:0]  rd_reg_addr_o;
    logic [31:0] rd_reg_data_i = 32'd0;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b1;
    logic [4:0]  dump_addr_o;
    logic [31:0] dump_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] csum_o;

    reg_dump_reader #(.SKIP_X0(SKIP)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .abort_i(abort_i),
        .first_addr_i(first_addr_i),
        .last_addr_i(last_addr_i),
        .rd_reg_en_o(rd_reg_en_o),
        .rd_reg_addr_o(rd_reg_addr_o),
        .rd_reg_data_i(rd_reg_data_i),
        .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i),
        .dump_addr_o(dump_addr_o),
        .dump_data_o(dump_data_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .csum_o(csum_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Regfile with a one-cycle registered debug read port.
    logic [31:0] regs [32];
    always @(posedge clk) if (rd_reg_en_o) rd_reg_data_i <= regs[rd_reg_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a dump is a list of words; each word takes 3 cycles plus consumer stall.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    word_t       mq[$];
    bit          m_busy = 0;
    bit          m_fin = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int          m_gap = 0;
    logic [31:0] m_csum = 32'd0;

    function automatic bit m_valid();
        return m_busy && !m_fin && (m_gap >= 3) && (mq.size() > 0);
    endfunction

    function automatic bit m_en();
        if (!(m_busy && !m_fin && m_gap == 1 && mq.size() > 0)) return 1'b0;
        return !(SKIP != 0 && mq[0].a == 5'd0);
    endfunction

    always @(posedge clk) begin
        bit    hs;
        word_t w;
        hs     = m_valid() && dump_ready_i;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst_i) begin
            mq.delete();
            m_busy = 0;
            m_fin  = 0;
            m_gap  = 0;
            m_csum = 32'd0;
        end else if (!m_busy) begin
            if (start_i && !abort_i) begin
                if (first_addr_i <= last_addr_i) begin
                    mq.delete();
                    for (int a = first_addr_i; a <= last_addr_i; a++) begin
                        w.a = 5'(a);
                        w.d = (SKIP != 0 && a == 0) ? 32'd0 : regs[a];
                        mq.push_back(w);
                    end
                    m_busy = 1;
                    m_fin  = 0;
                    m_gap  = 1;
                    m_csum = 32'd0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            if (hs) begin
                m_csum = m_csum ^ mq[0].d;
                void'(mq.pop_front());
            end
            if (abort_i) begin
                m_busy = 0;
                m_fin  = 0;
                mq.delete();
            end else if (m_fin) begin
                m_busy = 0;
                m_fin  = 0;
                m_done = 1'b1;
            end else if (hs) begin
                if (mq.size() == 0) m_fin = 1;
                else m_gap = 1;
            end else if (m_gap < 3) begin
                m_gap++;
            end
        end
    end

    // Event logs used by the directed scenarios.
    word_t log_q[$];
    int    en_cyc[$];
    int    vrise_cyc[$];
    int    done_cyc[$];
    int    err_cnt = 0;
    int    en0_cnt = 0;
    int    busy_cnt = 0;
    bit    prev_valid = 1'b0;

    always @(negedge clk) begin
        word_t w;
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
        chk("valid", {31'd0, dump_valid_o}, {31'd0, m_valid()});
        chk("rd_en", {31'd0, rd_reg_en_o}, {31'd0, m_en()});
        chk("done", {31'd0, done_o}, {31'd0, m_done});
        chk("err", {31'd0, err_o}, {31'd0, m_err});
`ifdef REG_DUMP_CHECKSUM_EN
        chk("csum", csum_o, m_csum);
`else
        chk("csum", csum_o, 32'd0);
`endif
        if (dump_valid_o && m_valid()) begin
            chk("dump_addr", {27'd0, dump_addr_o}, {27'd0, mq[0].a});
            chk("dump_data", dump_data_o, mq[0].d);
        end
        if (rd_reg_en_o && m_en()) chk("rd_addr", {27'd0, rd_reg_addr_o}, {27'd0, mq[0].a});

        if (dump_valid_o && dump_ready_i) begin
            w.a = dump_addr_o;
            w.d = dump_data_o;
            log_q.push_back(w);
            $display("word addr=%0d data=%h cycle=%0d", dump_addr_o, dump_data_o, cyc);
        end
        if (rd_reg_en_o) en_cyc.push_back(cyc);
        if (rd_reg_en_o && rd_reg_addr_o == 5'd0) en0_cnt++;
        if (dump_valid_o && !prev_valid) vrise_cyc.push_back(cyc);
        prev_valid = dump_valid_o;
        if (done_o) done_cyc.push_back(cyc);
        if (err_o) err_cnt++;
        if (busy_o) busy_cnt++;
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) dump_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
        start_i      = 1'b1;
        first_addr_i = f;
        last_addr_i  = l;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy_o || m_busy) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("wait_idle_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!dump_valid_o && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_word(input string name, input int idx, input logic [4:0] a, input logic [31:0] d);
        if (idx < log_q.size()) begin
            chk({name, "_addr"}, {27'd0, log_q[idx].a}, {27'd0, a});
            chk({name, "_data"}, log_q[idx].d, d);
        end else begin
            chk({name, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_rd_en"}, {31'd0, rd_reg_en_o}, 32'd0);
        chk({name, "_rd_addr"}, {27'd0, rd_reg_addr_o}, 32'd0);
        chk({name, "_valid"}, {31'd0, dump_valid_o}, 32'd0);
        chk({name, "_addr"}, {27'd0, dump_addr_o}, 32'd0);
        chk({name, "_data"}, dump_data_o, 32'd0);
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_done"}, {31'd0, done_o}, 32'd0);
        chk({name, "_err"}, {31'd0, err_o}, 32'd0);
        chk({name, "_csum"}, csum_o, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, b_en, b_v, b_d, b_l, b_e, b_b, b_z;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rst_i = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_i = 1'b0;
        tick();

        // Single register: read at +1, valid at +3, done at +5.
        regs[5] = 32'hDEADBEEF;
        b_en = en_cyc.size(); b_v = vrise_cyc.size(); b_d = done_cyc.size(); b_l = log_q.size();
        c0 = cyc;
        pulse_start(5'd5, 5'd5);
        wait_idle(50);
        chk("single_en_cycle", qget(en_cyc, b_en), c0 + 1);
        chk("single_en_count", en_cyc.size() - b_en, 1);
        chk("single_valid_cycle", qget(vrise_cyc, b_v), c0 + 3);
        chk("single_done_cycle", qget(done_cyc, b_d), c0 + 5);
        check_word("single_word", b_l, 5'd5, 32'hDEADBEEF);

        // Range starting at x0: x0 reported as zero without a read.
        regs[0] = 32'hA5A5A5A5; regs[1] = 32'h11; regs[2] = 32'h22;
        b_l = log_q.size(); b_z = en0_cnt;
        pulse_start(5'd0, 5'd2);
        wait_idle(60);
        chk("x0_words", log_q.size() - b_l, 3);
        check_word("x0_w0", b_l, 5'd0, 32'h0);
        check_word("x0_w1", b_l + 1, 5'd1, 32'h11);
        check_word("x0_w2", b_l + 2, 5'd2, 32'h22);
        chk("x0_no_read", en0_cnt - b_z, 0);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("x0_csum", csum_o, 32'h33);
`else
        chk("x0_csum", csum_o, 32'h0);
`endif

        // Top of the register file with consumer stall on the first word.
        regs[30] = 32'h3030_3030; regs[31] = 32'h3131_3131;
        b_l = log_q.size(); b_d = done_cyc.size();
        dump_ready_i = 1'b0;
        pulse_start(5'd30, 5'd31);
        wait_valid(20);
        for (int i = 0; i < 4; i++) tick();
        chk("top_held_addr", {27'd0, dump_addr_o}, 32'd30);
        chk("top_held_valid", {31'd0, dump_valid_o}, 32'd1);
        dump_ready_i = 1'b1;
        wait_idle(60);
        chk("top_words", log_q.size() - b_l, 2);
        check_word("top_w0", b_l, 5'd30, 32'h3030_3030);
        check_word("top_w1", b_l + 1, 5'd31, 32'h3131_3131);
        chk("top_done", done_cyc.size() - b_d, 1);

        // Reversed range.
        b_e = err_cnt; b_b = busy_cnt; b_en = en_cyc.size(); b_d = done_cyc.size();
        pulse_start(5'd9, 5'd3);
        tick(); tick(); tick();
        chk("rev_err_pulses", err_cnt - b_e, 1);
        chk("rev_busy", busy_cnt - b_b, 0);
        chk("rev_reads", en_cyc.size() - b_en, 0);
        chk("rev_done", done_cyc.size() - b_d, 0);

        // Abort during CAPTURE, then a fresh dump.
        b_v = vrise_cyc.size(); b_d = done_cyc.size();
        pulse_start(5'd4, 5'd8);
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_valid", {31'd0, dump_valid_o}, 32'd0);
        tick(); tick(); tick();
        chk("abort_no_valid", vrise_cyc.size() - b_v, 0);
        chk("abort_no_done", done_cyc.size() - b_d, 0);
        b_l = log_q.size();
        pulse_start(5'd4, 5'd5);
        wait_idle(60);
        chk("after_abort_done", done_cyc.size() - b_d, 1);
        check_word("after_abort_w0", b_l, 5'd4, regs[4]);
        check_word("after_abort_w1", b_l + 1, 5'd5, regs[5]);

        // Start while busy is ignored.
        b_l = log_q.size();
        pulse_start(5'd12, 5'd13);
        pulse_start(5'd20, 5'd20);
        wait_idle(60);
        chk("busy_start_words", log_q.size() - b_l, 2);
        check_word("busy_start_w0", b_l, 5'd12, regs[12]);
        check_word("busy_start_w1", b_l + 1, 5'd13, regs[13]);

        // Reset while a word is pending.
        dump_ready_i = 1'b0;
        pulse_start(5'd10, 5'd12);
        wait_valid(20);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_outputs_zero("rst_in_out");
        dump_ready_i = 1'b1;
        tick();

        // Start and abort together in IDLE: start is dropped.
        b_b = busy_cnt; b_e = err_cnt;
        start_i = 1'b1; abort_i = 1'b1; first_addr_i = 5'd1; last_addr_i = 5'd3;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        tick(); tick();
        chk("start_abort_busy", busy_cnt - b_b, 0);
        chk("start_abort_err", err_cnt - b_e, 0);

        // Randomized dumps against the model.
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            logic [4:0] f, l;
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = 5'($urandom_range(0, 31));
            l = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(f, 31));
            if ($urandom_range(0, 7) == 0) begin
                start_i = 1'b1; abort_i = 1'b1; first_addr_i = f; last_addr_i = l;
                tick();
                start_i = 1'b0; abort_i = 1'b0;
            end
            pulse_start(f, l);
            if ($urandom_range(0, 3) == 0) begin
                int d = $urandom_range(0, 12);
                for (int i = 0; i < d; i++) tick();
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
            end
            wait_idle(600);
        end
        rand_ready = 1'b0;
        dump_ready_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
